muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file. It consumes the two read-port operands (rd1/rd2) plus the destination register address. It produces a result and destination address, which the writeback path drives into the register file's write port (ad3/we3/wd3). It is a multi-cycle FSM: a shift-add multiplier and a restoring divider share one 32-iteration datapath, with a start/busy/done handshake toward the control unit.

## Interface

**Parameters**
- `DATA_WDTH`, default 32: operand/result width. Only 32 is supported for RV32M.
- `ADDR_WDTH`, default 5: width of the register address.

**Ports**
- `clk_i`, in, 1: the single clock; all state updates on the rising edge.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `start_i`, in, 1: request a new operation. Sampled only when `busy_o`=0.
- `kill_i`, in, 1: pipeline flush; aborts any in-flight operation.
- `op_i`, in, 3: M-extension funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a_i`, in, DATA_WDTH: rs1 operand (from rd1).
- `b_i`, in, DATA_WDTH: rs2 operand (from rd2).
- `rd_i`, in, ADDR_WDTH: destination register address.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle pulse; `result_o`/`rd_o` are valid in this cycle. Drives we3.
- `result_o`, out, DATA_WDTH: final result.
- `rd_o`, out, ADDR_WDTH: destination address latched at start.

## Operation

**States: IDLE, CALC, FIXUP, DONE.**
- **IDLE**, with `start_i`=1 and `kill_i`=0:
  - Latch `op_i` and `rd_i`.
  - Latch the absolute values of the operands. Sign-interpretation rules:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: a signed, b unsigned.
    - MULHU, DIVU, REMU: both operands unsigned.
    - MUL: either interpretation; the low word is identical.
  - Record the result sign.
  - Clear the 6-bit iteration counter.
  - Next state: CALC, except special cases go straight to FIXUP.
- **Special cases:**
  - Divide by zero (b=0, any divide/rem op): quotient = 0xFFFFFFFF, remainder = a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **CALC**: one iteration per edge.
  - Multiply: conditional add of the multiplicand into the upper half of a 64-bit accumulator, then shift right.
  - Divide: shift the remainder/quotient pair left, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - After the 32nd iteration (counter = 31), go to FIXUP.
- **FIXUP**:
  - Apply the recorded sign: two's-complement negate.
    - Product negated if the signs differ.
    - Quotient negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - Select the output word:
    - MUL: low 32 bits.
    - MULH/MULHSU/MULHU: high 32 bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selection into `result_o`. Next state: DONE.
- **DONE**: `done_o`=1 for exactly this cycle, then return to IDLE.
- **Holding and ignored starts:**
  - `result_o`/`rd_o` hold their values until the next accepted start.
  - A start while `busy_o`=1 (including in DONE) is ignored, not queued.
- **kill_i**:
  - In any non-IDLE state, go to IDLE on the next edge; no `done_o` is produced.
  - `kill_i` in IDLE blocks a simultaneous `start_i`.
  - `kill_i` has priority over all transitions.
- **rd_i = 0**: the operation executes normally and `done_o` still pulses; the register file discards the write to x0.

## Timing

- **Reset values:** state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, `rd_o`=0, counter 0.
- **Reset mid-operation:** takes effect immediately (asynchronous); the operation is lost.
- **Normal latency:**
  - Start accepted at edge E0.
  - CALC iterations on edges E1–E32, FIXUP on E33.
  - `done_o` is high in the cycle following E33, i.e. 34 cycles after the start cycle.
  - `busy_o` is high from the cycle after E0 through the DONE cycle.
- **Special-case latency:** E0 → FIXUP, E1 → DONE; `done_o` is high 2 cycles after the start cycle.
- **Throughput:** minimum start-to-start spacing is 35 cycles for the normal path and 3 for special cases.

## Structure

- **Package `muldiv_pkg`:**
  - `muldiv_op_t`: enum of the eight funct3 encodings.
  - `muldiv_state_t`: enum IDLE/CALC/FIXUP/DONE.
  - Localparam `MULDIV_ITERS` = 32.
- **Single module, no sub-module.** The shared 64-bit accumulator and adder/subtractor are natural inside one always_ff/always_comb pair.

## Test plan

- MUL a=7, b=0xFFFFFFFD (−3) → `result_o`=0xFFFFFFEB; `done_o` pulses once, 34 cycles after start; `rd_o` equals `rd_i`.
- a=b=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
- a=0xFFFFFFF9 (−7), b=2:
  - DIV → 0xFFFFFFFD (−3)
  - REM → 0xFFFFFFFF (−1)
  - DIVU → 0x7FFFFFFC
- Special cases, each with `done_o` 2 cycles after start:
  - DIVU a=0x1234, b=0 → 0xFFFFFFFF
  - REM a=0x1234, b=0 → 0x1234
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000
  - REM with the same operands → 0
- Start at cycle 5 of a running DIV → ignored; the original result is unchanged. Then `kill_i` at cycle 10 of a new MUL → IDLE next cycle, no `done_o`, `result_o` keeps its previous value.
- Assert `rst_i` mid-CALC → `busy_o`, `done_o`, `result_o`, `rd_o` go to 0 asynchronously. A start after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   muldiv_op_t    - funct3 encodings of the M-extension operations
//   muldiv_state_t - control FSM states
//   MULDIV_ITERS   - datapath iterations per normal operation
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERS = 32;
  localparam int unsigned CNT_WDTH     = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } muldiv_state_t;

  // Divide and remainder operations share the divider datapath.
  function automatic logic is_div(muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // MUL is treated as signed; its low word is the same either way.
  function automatic logic a_signed(muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between control unit / register file
// and the multiply/divide unit.
//   start_i, kill_i, op_i, a_i, b_i, rd_i : request side (master drives)
//   busy_o, done_o, result_o, rd_o         : response side (slave drives)
interface muldiv_if #(
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned ADDR_WDTH = 5
);

  logic                 start_i;
  logic                 kill_i;
  logic [2:0]           op_i;
  logic [DATA_WDTH-1:0] a_i;
  logic [DATA_WDTH-1:0] b_i;
  logic [ADDR_WDTH-1:0] rd_i;
  logic                 busy_o;
  logic                 done_o;
  logic [DATA_WDTH-1:0] result_o;
  logic [ADDR_WDTH-1:0] rd_o;

  modport master (
    output start_i, kill_i, op_i, a_i, b_i, rd_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, kill_i, op_i, a_i, b_i, rd_i,
    output busy_o, done_o, result_o, rd_o
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit. A shift-add multiplier
// and a restoring divider share one 64-bit accumulator and 32 iterations.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : start/kill/op/operands/rd in; busy/done/result/rd out
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned ADDR_WDTH = 5
) (
  input  logic    clk_i,
  input  logic    rst_i,
  muldiv_if.slave bus
);

  localparam int unsigned ACC_WDTH = 2 * DATA_WDTH;
  localparam logic [DATA_WDTH-1:0] ONES = '1;
  localparam logic [DATA_WDTH-1:0] MIN_NEG = {1'b1, {(DATA_WDTH-1){1'b0}}};

  muldiv_state_t        state, state_next;
  logic [CNT_WDTH-1:0]  cnt;
  logic [ACC_WDTH-1:0]  acc;        // mul: {hi, multiplier}; div: {rem, quo}
  logic [DATA_WDTH-1:0] opnd;       // multiplicand or divisor magnitude
  muldiv_op_t           op_q;
  logic                 neg_res;    // product/quotient must be negated
  logic                 neg_rem;    // remainder follows dividend sign
  logic                 special_q;  // result preloaded, skip sign fixup
  logic                 busy_q;
  logic                 done_q;
  logic [DATA_WDTH-1:0] result_q;
  logic [ADDR_WDTH-1:0] rd_q;

  muldiv_op_t           op_in;
  logic                 a_neg, b_neg, div_zero, div_ovf, special, accept;
  logic [DATA_WDTH-1:0] a_abs, b_abs;

  logic [DATA_WDTH:0]   mul_sum, div_rem_sh, div_trial;
  logic [ACC_WDTH-1:0]  acc_mul, acc_div, prod;
  logic [DATA_WDTH-1:0] quo_fix, rem_fix, fix_result;

  assign op_in = muldiv_op_t'(bus.op_i);

  // Operand decode: magnitudes, signs and special-case detection.
  always_comb begin
    a_neg    = a_signed(op_in) & bus.a_i[DATA_WDTH-1];
    b_neg    = b_signed(op_in) & bus.b_i[DATA_WDTH-1];
    a_abs    = a_neg ? DATA_WDTH'(-bus.a_i) : bus.a_i;
    b_abs    = b_neg ? DATA_WDTH'(-bus.b_i) : bus.b_i;
    div_zero = is_div(op_in) && (bus.b_i == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
               (bus.a_i == MIN_NEG) && (bus.b_i == ONES);
    special  = div_zero || div_ovf;
    accept   = (state == ST_IDLE) && bus.start_i && !bus.kill_i;
  end

  // One iteration of each algorithm.
  always_comb begin
    mul_sum    = {1'b0, acc[ACC_WDTH-1:DATA_WDTH]} +
                 (acc[0] ? {1'b0, opnd} : '0);
    acc_mul    = {mul_sum, acc[DATA_WDTH-1:1]};
    // Remainder after the left shift needs one extra bit before the trial.
    div_rem_sh = acc[ACC_WDTH-1:DATA_WDTH-1];
    div_trial  = div_rem_sh - {1'b0, opnd};
    acc_div    = div_trial[DATA_WDTH] ?
                 {acc[ACC_WDTH-2:0], 1'b0} :
                 {div_trial[DATA_WDTH-1:0], acc[DATA_WDTH-2:0], 1'b1};
  end

  // Sign fixup and output word selection.
  always_comb begin
    prod    = neg_res ? ACC_WDTH'(-acc) : acc;
    quo_fix = (neg_res && !special_q) ? DATA_WDTH'(-acc[DATA_WDTH-1:0])
                                      : acc[DATA_WDTH-1:0];
    rem_fix = (neg_rem && !special_q) ? DATA_WDTH'(-acc[ACC_WDTH-1:DATA_WDTH])
                                      : acc[ACC_WDTH-1:DATA_WDTH];
    case (op_q)
      OP_MUL:                       fix_result = prod[DATA_WDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[ACC_WDTH-1:DATA_WDTH];
      OP_DIV, OP_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = special ? ST_FIXUP : ST_CALC;
      ST_CALC:  if (cnt == CNT_WDTH'(MULDIV_ITERS - 1)) state_next = ST_FIXUP;
      ST_FIXUP: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (bus.kill_i) state_next = ST_IDLE;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_q      <= OP_MUL;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      busy_q <= (state_next != ST_IDLE);
      done_q <= (state_next == ST_DONE);
      if (accept) begin
        op_q      <= op_in;
        rd_q      <= bus.rd_i;
        cnt       <= '0;
        neg_res   <= a_neg ^ b_neg;
        neg_rem   <= a_neg;
        special_q <= special;
        if (div_zero) begin
          acc  <= {bus.a_i, ONES};
          opnd <= b_abs;
        end else if (div_ovf) begin
          acc  <= {{DATA_WDTH{1'b0}}, MIN_NEG};
          opnd <= b_abs;
        end else if (is_div(op_in)) begin
          acc  <= {{DATA_WDTH{1'b0}}, a_abs};
          opnd <= b_abs;
        end else begin
          acc  <= {{DATA_WDTH{1'b0}}, b_abs};
          opnd <= a_abs;
        end
      end else if (state == ST_CALC && !bus.kill_i) begin
        acc <= is_div(op_q) ? acc_div : acc_mul;
        cnt <= cnt + CNT_WDTH'(1);
      end
      if (state == ST_FIXUP && !bus.kill_i) result_q <= fix_result;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_q;

endmodule
